// File: rtl/rsa_avm_pkg.sv
// Shared constants for the RSA Avalon-MM frame wrapper: UART register map,
// command codes and the state encodings of the wrapper and RSA core FSMs.
package rsa_avm_pkg;

    localparam logic [4:0] AVM_ADDR_RX     = 5'd0;
    localparam logic [4:0] AVM_ADDR_TX     = 5'd4;
    localparam logic [4:0] AVM_ADDR_STATUS = 5'd8;

    localparam int STATUS_RX_RDY_BIT = 7;
    localparam int STATUS_TX_RDY_BIT = 6;

    localparam logic [7:0] CMD_KEY  = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h02;
    localparam logic [7:0] NAK_BYTE = 8'hFF;

    localparam logic [2:0] ST_CMD   = 3'd0;
    localparam logic [2:0] ST_GET_N = 3'd1;
    localparam logic [2:0] ST_GET_D = 3'd2;
    localparam logic [2:0] ST_GET_A = 3'd3;
    localparam logic [2:0] ST_START = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_SEND  = 3'd6;
    localparam logic [2:0] ST_NAK   = 3'd7;

    localparam logic [2:0] CORE_IDLE = 3'd0;
    localparam logic [2:0] CORE_SCAN = 3'd1;
    localparam logic [2:0] CORE_NEXT = 3'd2;
    localparam logic [2:0] CORE_SQR  = 3'd3;
    localparam logic [2:0] CORE_MUL  = 3'd4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rsa_avm_frame_wrapper_core.sv
// Parametrised RSA core: o_a_pow_d = i_a ** i_d mod i_n, left-to-right
// square-and-multiply over a bit-serial interleaved modular multiplier.
module rsa_avm_frame_wrapper_core
    import rsa_avm_pkg::*;
#(
    parameter int BITWIDTH = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [BITWIDTH-1:0] i_a,
    input  logic [BITWIDTH-1:0] i_d,
    input  logic [BITWIDTH-1:0] i_n,
    output logic [BITWIDTH-1:0] o_a_pow_d,
    output logic                o_finished
);

    localparam int CNT_W = $clog2(BITWIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITWIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BITWIDTH-1:0] ONE_W = {{(BITWIDTH-1){1'b0}}, 1'b1};

    logic [2:0]          st_q, st_d;
    logic [BITWIDTH-1:0] n_q, n_d, base_q, base_d, exp_q, exp_d, acc_q, acc_d;
    logic [BITWIDTH-1:0] mm_x_q, mm_x_d, mm_y_q, mm_y_d, mm_r_q, mm_r_d;
    logic [CNT_W-1:0]    bits_q, bits_d, mm_cnt_q, mm_cnt_d;
    logic                fin_q, fin_d;

    logic [BITWIDTH:0]   dbl_s, dbl_red_s, sum_s, sum_red_s;
    logic [BITWIDTH-1:0] mm_next_s;
    logic                core_unused_s;

    // One interleaved step: r = 2r + x_msb*y, kept below n (needs r, y < n).
    always_comb begin
        dbl_s     = {mm_r_q, 1'b0};
        dbl_red_s = (dbl_s >= {1'b0, n_q}) ? dbl_s - {1'b0, n_q} : dbl_s;
        sum_s     = mm_x_q[BITWIDTH-1] ? dbl_red_s + {1'b0, mm_y_q} : dbl_red_s;
        sum_red_s = (sum_s >= {1'b0, n_q}) ? sum_s - {1'b0, n_q} : sum_s;
        mm_next_s = sum_red_s[BITWIDTH-1:0];
    end

    assign core_unused_s = sum_red_s[BITWIDTH];

    // Exponent sequencing: skip leading zeros, then square per bit and multiply on ones.
    always_comb begin
        st_d     = st_q;
        n_d      = n_q;
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        mm_x_d   = mm_x_q;
        mm_y_d   = mm_y_q;
        mm_r_d   = mm_r_q;
        bits_d   = bits_q;
        mm_cnt_d = mm_cnt_q;
        fin_d    = 1'b0;
        case (st_q)
            CORE_IDLE: begin
                if (i_start) begin
                    n_d    = i_n;
                    base_d = i_a;
                    exp_d  = i_d;
                    acc_d  = ONE_W;
                    bits_d = CNT_FULL;
                    st_d   = CORE_SCAN;
                end else begin
                    st_d = CORE_IDLE;
                end
            end
            CORE_SCAN: begin
                if (bits_q == '0) begin
                    fin_d = 1'b1;
                    st_d  = CORE_IDLE;
                end else begin
                    exp_d  = exp_q << 1;
                    bits_d = bits_q - CNT_ONE;
                    acc_d  = exp_q[BITWIDTH-1] ? base_q : acc_q;
                    st_d   = exp_q[BITWIDTH-1] ? CORE_NEXT : CORE_SCAN;
                end
            end
            CORE_NEXT: begin
                if (bits_q == '0) begin
                    fin_d = 1'b1;
                    st_d  = CORE_IDLE;
                end else begin
                    mm_x_d   = acc_q;
                    mm_y_d   = acc_q;
                    mm_r_d   = '0;
                    mm_cnt_d = CNT_FULL;
                    st_d     = CORE_SQR;
                end
            end
            CORE_SQR, CORE_MUL: begin
                mm_x_d   = mm_x_q << 1;
                mm_r_d   = mm_next_s;
                mm_cnt_d = mm_cnt_q - CNT_ONE;
                if (mm_cnt_q == CNT_ONE) begin
                    if (st_q == CORE_SQR) begin
                        exp_d  = exp_q << 1;
                        bits_d = bits_q - CNT_ONE;
                    end else begin
                        bits_d = bits_q;
                    end
                    if ((st_q == CORE_SQR) && exp_q[BITWIDTH-1]) begin
                        mm_x_d   = base_q;
                        mm_y_d   = mm_next_s;
                        mm_r_d   = '0;
                        mm_cnt_d = CNT_FULL;
                        st_d     = CORE_MUL;
                    end else begin
                        acc_d = mm_next_s;
                        st_d  = CORE_NEXT;
                    end
                end else begin
                    st_d = st_q;
                end
            end
            default: st_d = CORE_IDLE;
        endcase
    end

    // Core state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q     <= CORE_IDLE;
            n_q      <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            mm_x_q   <= '0;
            mm_y_q   <= '0;
            mm_r_q   <= '0;
            bits_q   <= '0;
            mm_cnt_q <= '0;
            fin_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            n_q      <= n_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            mm_x_q   <= mm_x_d;
            mm_y_q   <= mm_y_d;
            mm_r_q   <= mm_r_d;
            bits_q   <= bits_d;
            mm_cnt_q <= mm_cnt_d;
            fin_q    <= fin_d;
        end
    end

    assign o_a_pow_d  = acc_q;
    assign o_finished = fin_q;

endmodule

// File: rtl/rsa_avm_frame_wrapper.sv
// Avalon-MM master that parses framed UART commands (KEY / DATA), runs the
// RSA core and returns the plaintext bytes (or a NAK) through the UART.
module rsa_avm_frame_wrapper
    import rsa_avm_pkg::*;
#(
    parameter int BITWIDTH  = 256,
    parameter int NBYTES    = BITWIDTH / 8,
    parameter int OUT_BYTES = BITWIDTH / 8 - 1
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic        o_key_valid,
    output logic [15:0] o_blocks_done,
    output logic [7:0]  o_bad_cmd
);

    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]          state_q, state_d;
    logic                phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [4:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [BITWIDTH-1:0] n_q, n_d, dexp_q, dexp_d, a_q, a_d, res_q, res_d;
    logic                key_valid_q, key_valid_d;
    logic [15:0]         blocks_q, blocks_d;
    logic [7:0]          bad_q, bad_d;

    logic                rx_state_s, tx_state_s, bus_idle_s, rdy_s;
    logic [7:0]          rx_byte_s, tx_byte_s;
    logic                core_start_s, core_finished_s;
    logic [BITWIDTH-1:0] core_result_s;
    logic                readdata_unused_s;

    assign rx_state_s = (state_q == ST_CMD) || (state_q == ST_GET_N) ||
                        (state_q == ST_GET_D) || (state_q == ST_GET_A);
    assign tx_state_s = (state_q == ST_SEND) || (state_q == ST_NAK);
    assign bus_idle_s = !rd_q && !wr_q;
    assign rx_byte_s  = avm_readdata[7:0];
    assign rdy_s      = rx_state_s ? avm_readdata[STATUS_RX_RDY_BIT]
                                   : avm_readdata[STATUS_TX_RDY_BIT];
    assign tx_byte_s  = (state_q == ST_NAK) ? NAK_BYTE : res_q[OUT_BYTES*8-1 -: 8];
    assign core_start_s = (state_q == ST_START);
    assign readdata_unused_s = ^avm_readdata[31:8];

    // Every byte is a STATUS poll followed by one RX read or TX write; a new
    // request is only issued from an idle cycle, which guarantees the gap.
    always_comb begin
        logic [CNT_W-1:0] cnt_nxt;
        cnt_nxt     = cnt_q;
        state_d     = state_q;
        phase_d     = phase_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        n_d         = n_q;
        dexp_d      = dexp_q;
        a_d         = a_q;
        res_d       = res_q;
        key_valid_d = key_valid_q;
        blocks_d    = blocks_q;
        bad_d       = bad_q;
        if (rx_state_s || tx_state_s) begin
            if (bus_idle_s) begin
                if (!phase_q) begin
                    rd_d   = 1'b1;
                    addr_d = AVM_ADDR_STATUS;
                end else if (rx_state_s) begin
                    rd_d   = 1'b1;
                    addr_d = AVM_ADDR_RX;
                end else begin
                    wr_d    = 1'b1;
                    addr_d  = AVM_ADDR_TX;
                    wdata_d = {24'd0, tx_byte_s};
                end
            end else if (!avm_waitrequest) begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                phase_d = phase_q ? 1'b0 : rdy_s;
                if (phase_q) begin
                    case (state_q)
                        ST_CMD: begin
                            if (rx_byte_s == CMD_KEY) begin
                                state_d     = ST_GET_N;
                                key_valid_d = 1'b0;
                            end else if (rx_byte_s == CMD_DATA) begin
                                state_d = ST_GET_A;
                            end else begin
                                bad_d = sat_inc8(bad_q);
                            end
                        end
                        ST_GET_N: begin
                            n_d     = {n_q[BITWIDTH-9:0], rx_byte_s};
                            cnt_nxt = cnt_q + CNT_ONE;
                            state_d = (cnt_q == IN_LAST) ? ST_GET_D : ST_GET_N;
                        end
                        ST_GET_D: begin
                            dexp_d  = {dexp_q[BITWIDTH-9:0], rx_byte_s};
                            cnt_nxt = cnt_q + CNT_ONE;
                            if (cnt_q == IN_LAST) begin
                                state_d     = ST_CMD;
                                key_valid_d = 1'b1;
                            end else begin
                                state_d = ST_GET_D;
                            end
                        end
                        ST_GET_A: begin
                            a_d     = {a_q[BITWIDTH-9:0], rx_byte_s};
                            cnt_nxt = cnt_q + CNT_ONE;
                            if (cnt_q == IN_LAST) begin
                                state_d = key_valid_q ? ST_START : ST_NAK;
                            end else begin
                                state_d = ST_GET_A;
                            end
                        end
                        ST_SEND: begin
                            res_d   = res_q << 8;
                            cnt_nxt = cnt_q + CNT_ONE;
                            if (cnt_q == OUT_LAST) begin
                                state_d  = ST_CMD;
                                blocks_d = blocks_q + 16'd1;
                            end else begin
                                state_d = ST_SEND;
                            end
                        end
                        ST_NAK:  state_d = ST_CMD;
                        default: state_d = ST_CMD;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end else begin
                phase_d = phase_q;
            end
        end else if (state_q == ST_START) begin
            state_d = ST_WAIT;
        end else if (state_q == ST_WAIT) begin
            if (core_finished_s) begin
                res_d   = core_result_s;
                state_d = ST_SEND;
            end else begin
                state_d = ST_WAIT;
            end
        end else begin
            state_d = ST_CMD;
        end
        cnt_d = (state_d != state_q) ? '0 : cnt_nxt;
    end

    // Wrapper state, bus request and operand registers.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q     <= ST_CMD;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= AVM_ADDR_STATUS;
            wdata_q     <= 32'd0;
            n_q         <= '0;
            dexp_q      <= '0;
            a_q         <= '0;
            res_q       <= '0;
            key_valid_q <= 1'b0;
            blocks_q    <= 16'd0;
            bad_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            n_q         <= n_d;
            dexp_q      <= dexp_d;
            a_q         <= a_d;
            res_q       <= res_d;
            key_valid_q <= key_valid_d;
            blocks_q    <= blocks_d;
            bad_q       <= bad_d;
        end
    end

    rsa_avm_frame_wrapper_core #(
        .BITWIDTH(BITWIDTH)
    ) u_core (
        .i_clk     (avm_clk),
        .i_rst     (avm_rst),
        .i_start   (core_start_s),
        .i_a       (a_q),
        .i_d       (dexp_q),
        .i_n       (n_q),
        .o_a_pow_d (core_result_s),
        .o_finished(core_finished_s)
    );

    assign avm_address   = addr_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign o_key_valid   = key_valid_q;
    assign o_blocks_done = blocks_q;
    assign o_bad_cmd     = bad_q;

endmodule

// File: tb/tb_rsa_avm_frame_wrapper.sv
// Bench: UART slave model feeding framed commands, scoreboard of expected TX
// bytes from a plain-arithmetic RSA model, plus Avalon protocol checks.
module tb_rsa_avm_frame_wrapper;

    localparam int BW = 256;
    localparam int NB = BW / 8;
    localparam int OB = BW / 8 - 1;

    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_readdata, avm_writedata;
    logic        avm_waitrequest;
    logic        o_key_valid;
    logic [15:0] o_blocks_done;
    logic [7:0]  o_bad_cmd;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int   rx_delay = 5;
    int   polls = 0;
    bit   stall_en = 1'b0;
    bit   rx_seen = 1'b0, tx_seen = 1'b0;
    bit   pend_stall = 1'b0, prev_done = 1'b0, first_seen = 1'b0;
    bit   rx_ok, tx_ok;
    logic [38:0] saved_bus;

    bit          m_key_valid = 1'b0;
    logic [BW-1:0] m_n = '0, m_d = '0;
    logic [15:0] m_blocks = 16'd0;
    logic [7:0]  m_bad = 8'd0;

    always #5 avm_clk = ~avm_clk;

    rsa_avm_frame_wrapper #(.BITWIDTH(BW)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address),
        .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_key_valid(o_key_valid), .o_blocks_done(o_blocks_done), .o_bad_cmd(o_bad_cmd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] modexp(input logic [BW-1:0] a, input logic [BW-1:0] e,
                                             input logic [BW-1:0] n);
        logic [2*BW-1:0] r, b, nn;
        nn = {{BW{1'b0}}, n};
        r  = 1;
        b  = {{BW{1'b0}}, a} % nn;
        for (int i = 0; i < BW; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_wide();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < BW / 32; i++) v = {v[BW-33:0], 32'($urandom())};
        return v;
    endfunction

    task automatic push_wide(input logic [BW-1:0] v);
        for (int k = NB - 1; k >= 0; k--) rx_q.push_back(v[8*k +: 8]);
    endtask

    task automatic send_key(input logic [BW-1:0] n, input logic [BW-1:0] d);
        rx_q.push_back(8'h01);
        push_wide(n);
        push_wide(d);
        m_n = n;
        m_d = d;
        m_key_valid = 1'b1;
    endtask

    task automatic send_data(input logic [BW-1:0] a);
        logic [BW-1:0] p;
        rx_q.push_back(8'h02);
        push_wide(a);
        if (m_key_valid) begin
            p = modexp(a, m_d, m_n);
            for (int k = OB - 1; k >= 0; k--) exp_q.push_back(p[8*k +: 8]);
            m_blocks = m_blocks + 16'd1;
        end else begin
            exp_q.push_back(8'hFF);
        end
    endtask

    task automatic send_bad(input logic [7:0] b);
        rx_q.push_back(b);
        m_bad = (m_bad == 8'hFF) ? m_bad : m_bad + 8'd1;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0) && cyc < 30000) begin
            @(posedge avm_clk);
            cyc++;
        end
        check(tag, 64'(rx_q.size() + exp_q.size()), 64'd0);
        repeat (4) @(posedge avm_clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_key_valid"}, 64'(o_key_valid), 64'(m_key_valid));
        check({tag, "_blocks"}, 64'(o_blocks_done), 64'(m_blocks));
        check({tag, "_bad_cmd"}, 64'(o_bad_cmd), 64'(m_bad));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 64'(avm_address), 64'd8);
        check({tag, "_read"}, 64'(avm_read), 64'd0);
        check({tag, "_write"}, 64'(avm_write), 64'd0);
        check({tag, "_wdata"}, 64'(avm_writedata), 64'd0);
        check_counters(tag);
    endtask

    function automatic logic [BW-1:0] rand_modulus();
        logic [BW-1:0] v;
        v = rand_wide();
        v[BW-1] = 1'b1;
        v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_exp();
        logic [BW-1:0] v;
        v = '0;
        v[11:0] = 12'($urandom_range(2048, 4095));
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_cipher();
        logic [BW-1:0] v;
        v = rand_wide();
        v[BW-1] = 1'b0;
        return v;
    endfunction

    // UART slave and monitor: answers the bus at negedge, pops the scoreboard on TX writes.
    always @(negedge avm_clk) begin
        if (avm_rst) begin
            pend_stall = 1'b0;
            prev_done = 1'b0;
            rx_seen = 1'b0;
            tx_seen = 1'b0;
            polls = 0;
            avm_waitrequest = 1'b0;
        end else begin
            if (pend_stall) check("stall_hold", 64'({avm_address, avm_read, avm_write, avm_writedata}), 64'(saved_bus));
            if (prev_done) check("idle_gap", 64'({avm_read, avm_write}), 64'd0);
            pend_stall = 1'b0;
            prev_done = 1'b0;
            if (avm_read || avm_write) begin
                check("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_addr", 64'(avm_address), 64'd8);
                    check("first_is_read", 64'(avm_read), 64'd1);
                end
                avm_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
                rx_ok = (rx_q.size() > 0) && (polls >= rx_delay);
                tx_ok = ($urandom_range(0, 3) != 0);
                if (avm_read && avm_address == 5'd8)
                    avm_readdata = {24'd0, rx_ok, tx_ok, 6'd0};
                else if (avm_read && avm_address == 5'd0 && rx_q.size() > 0)
                    avm_readdata = {24'd0, rx_q[0]};
                else
                    avm_readdata = 32'($urandom());
                if (avm_waitrequest) begin
                    pend_stall = 1'b1;
                    saved_bus = {avm_address, avm_read, avm_write, avm_writedata};
                end else begin
                    prev_done = 1'b1;
                    if (avm_read && avm_address == 5'd8) begin
                        rx_seen = rx_ok;
                        tx_seen = tx_ok;
                        if (!rx_ok) polls++;
                    end else if (avm_read && avm_address == 5'd0) begin
                        check("rx_after_ready", 64'(rx_seen), 64'd1);
                        check("rx_nonempty", 64'(rx_q.size() > 0), 64'd1);
                        if (rx_q.size() > 0) void'(rx_q.pop_front());
                        rx_seen = 1'b0;
                        polls = 0;
                    end else if (avm_write) begin
                        check("tx_addr", 64'(avm_address), 64'd4);
                        check("tx_after_ready", 64'(tx_seen), 64'd1);
                        tx_seen = 1'b0;
                        check("tx_expected", 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) check("tx_byte", 64'(avm_writedata), 64'({24'd0, exp_q.pop_front()}));
                    end else begin
                        check("read_addr_valid", 64'(avm_address), 64'd8);
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    initial begin
        avm_rst = 1'b1;
        avm_readdata = 32'd0;
        avm_waitrequest = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge avm_clk);
        avm_rst = 1'b0;

        // DATA before any key: consumed, single NAK byte
        send_data(rand_cipher());
        wait_idle("nak_no_key");
        check_counters("nak_no_key");
        rx_delay = 1;

        send_key(rand_modulus(), rand_exp());
        wait_idle("key1");
        check_counters("key1");

        send_data(rand_cipher());
        wait_idle("data1");
        check_counters("data1");

        send_bad(8'h7A);
        send_data(rand_cipher());
        wait_idle("bad_then_data");
        check_counters("bad_then_data");

        stall_en = 1'b1;
        send_data(rand_cipher());
        wait_idle("stalled_data");
        send_key(rand_modulus(), rand_exp());
        send_data(rand_cipher());
        wait_idle("stalled_rekey");
        check_counters("stalled_rekey");
        stall_en = 1'b0;

        // Partial DATA frame, then asynchronous reset inside GET_A
        rx_q.push_back(8'h02);
        for (int k = 0; k < 10; k++) rx_q.push_back(8'($urandom()));
        wait_idle("partial_frame");
        #3;
        avm_rst = 1'b1;
        m_key_valid = 1'b0;
        m_blocks = 16'd0;
        m_bad = 8'd0;
        rx_q.delete();
        exp_q.delete();
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge avm_clk);
        avm_rst = 1'b0;

        send_data(rand_cipher());
        send_key(rand_modulus(), rand_exp());
        send_data(rand_cipher());
        wait_idle("after_reset");
        check_counters("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
